// File: rtl/accel_csr_pkg.sv
// -----------------------------------------------------------------------------
// accel_csr_pkg
// Shared definitions for the accelerator control/status register block:
// register word indices (address bits [4:2]), AXI-Lite response codes, the
// cfg_k reset value and the write/read channel FSM state types.
// -----------------------------------------------------------------------------
package accel_csr_pkg;

  // Register word indices. Byte offset = index * 4.
  localparam logic [2:0] REG_CTRL    = 3'd0;  // 0x00 WO
  localparam logic [2:0] REG_STATUS  = 3'd1;  // 0x04 RO
  localparam logic [2:0] REG_CFG_K   = 3'd2;  // 0x08 RW
  localparam logic [2:0] REG_JOB_CNT = 3'd3;  // 0x0C RO
  localparam logic [2:0] REG_IER     = 3'd4;  // 0x10 RW (irq build only)
  localparam logic [2:0] REG_ISR     = 3'd5;  // 0x14 W1C (irq build only)

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [15:0] CFG_K_RESET = 16'd4;

  typedef enum logic { W_IDLE, W_RESP } wr_state_e;
  typedef enum logic { R_IDLE, R_DATA } rd_state_e;

endpackage

// File: rtl/accel_ctrl_regs.sv
// -----------------------------------------------------------------------------
// accel_ctrl_regs
// AXI-Lite control/status registers driving the compute_wrapper control plane.
// Generates start / sw_clear_done pulses, holds cfg_k, tracks BUSY and counts
// completed jobs (rising edges of the core's sticky done).
//
// Optional feature: define ACCEL_CTRL_IRQ_EN to add the irq output together
// with the IER (0x10) and ISR (0x14, W1C) registers.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*      AXI-Lite write address / data / response channels
//   s_axil_ar*/r*         AXI-Lite read address / data channels
//   start                 one-cycle job start pulse to the core
//   sw_clear_done         one-cycle pulse clearing the core's sticky done
//   cfg_k                 K dimension to the core
//   done                  sticky done from the core
//   irq                   (ACCEL_CTRL_IRQ_EN only) ISR[0] & IER[0], registered
// -----------------------------------------------------------------------------
module accel_ctrl_regs
  import accel_csr_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int K_MAX  = 64
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,

  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,

  output logic              start,
  output logic              sw_clear_done,
  output logic [15:0]       cfg_k,
  input  logic              done
`ifdef ACCEL_CTRL_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [15:0] K_MAX_W = 16'(K_MAX);

  wr_state_e   wr_state;
  rd_state_e   rd_state;
  logic        busy;
  logic        done_q;
  logic [31:0] job_cnt;
  logic        done_rise;

  logic [2:0]  wr_idx;
  logic [2:0]  rd_idx;
  logic [15:0] wr_k;
  logic        wr_hs;
  logic        rd_hs;

  // Decoded effect of the write currently presented on AW/W.
  logic [1:0]  wr_resp;
  logic        wr_start;
  logic        wr_clr;
  logic        wr_k_ok;

  logic [31:0] rd_data_c;
  logic [1:0]  rd_resp_c;

`ifdef ACCEL_CTRL_IRQ_EN
  logic        ier;
  logic        isr;
  logic        wr_ier;
  logic        wr_isr_clr;
`endif

  // wstrb is ignored (full-word writes), only address bits [4:2] decode and
  // cfg_k uses the low half of wdata.
  logic        unused_bits;
  assign unused_bits = ^{s_axil_wstrb, s_axil_awaddr, s_axil_araddr,
                         s_axil_wdata[31:16]};

  assign done_rise = done & ~done_q;
  assign wr_idx    = s_axil_awaddr[4:2];
  assign rd_idx    = s_axil_araddr[4:2];
  assign wr_k      = s_axil_wdata[15:0];

  // AW and W are taken together in one cycle, only from W_IDLE, so a write
  // costs at least two cycles (accept, respond).
  assign wr_hs          = (wr_state == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
  assign s_axil_awready = wr_hs;
  assign s_axil_wready  = wr_hs;
  assign rd_hs          = (rd_state == R_IDLE) && s_axil_arvalid;
  assign s_axil_arready = rd_hs;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    wr_resp  = RESP_OKAY;
    wr_start = 1'b0;
    wr_clr   = 1'b0;
    wr_k_ok  = 1'b0;
`ifdef ACCEL_CTRL_IRQ_EN
    wr_ier     = 1'b0;
    wr_isr_clr = 1'b0;
`endif
    case (wr_idx)
      REG_CTRL: begin
        // START is silently dropped while a job is running.
        wr_start = s_axil_wdata[0] & ~busy;
        wr_clr   = s_axil_wdata[1];
      end
      REG_STATUS, REG_JOB_CNT: begin
        // Read-only: write ignored, still OKAY.
      end
      REG_CFG_K: begin
        if (busy || (wr_k == 16'd0) || (wr_k > K_MAX_W)) wr_resp = RESP_SLVERR;
        else                                              wr_k_ok = 1'b1;
      end
`ifdef ACCEL_CTRL_IRQ_EN
      REG_IER: wr_ier     = 1'b1;
      REG_ISR: wr_isr_clr = s_axil_wdata[0];
`endif
      default: wr_resp = RESP_SLVERR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state      <= W_IDLE;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_hs) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= wr_resp;
            wr_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            wr_state      <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start         <= 1'b0;
      sw_clear_done <= 1'b0;
      cfg_k         <= CFG_K_RESET;
      busy          <= 1'b0;
      done_q        <= 1'b0;
      job_cnt       <= 32'd0;
    end else begin
      start         <= wr_hs & wr_start;
      sw_clear_done <= wr_hs & wr_clr;
      done_q        <= done;

      // Counts every rising edge, including a stray one while idle; wraps.
      if (done_rise) job_cnt <= job_cnt + 32'd1;

      // An accepted START implies BUSY=0, when done cannot legitimately rise,
      // so giving START priority only matters for a glitching core.
      if (wr_hs && wr_start) busy <= 1'b1;
      else if (done_rise)    busy <= 1'b0;

      if (wr_hs && wr_k_ok) cfg_k <= wr_k;
    end
  end

`ifdef ACCEL_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier <= 1'b0;
      isr <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_hs && wr_ier) ier <= s_axil_wdata[0];
      // A new completion beats a simultaneous software clear.
      if (done_rise)                isr <= 1'b1;
      else if (wr_hs && wr_isr_clr) isr <= 1'b0;
      irq <= isr & ier;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read decode and read channel FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_c = 32'd0;
    rd_resp_c = RESP_OKAY;
    case (rd_idx)
      REG_CTRL:    rd_data_c = 32'd0;
      REG_STATUS:  rd_data_c = {30'd0, busy, done};
      REG_CFG_K:   rd_data_c = {16'd0, cfg_k};
      REG_JOB_CNT: rd_data_c = job_cnt;
`ifdef ACCEL_CTRL_IRQ_EN
      REG_IER:     rd_data_c = {31'd0, ier};
      REG_ISR:     rd_data_c = {31'd0, isr};
`endif
      default:     rd_resp_c = RESP_SLVERR;
    endcase
  end

  // Data is captured from pre-edge register values, so a read racing a write
  // to the same register returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state      <= R_IDLE;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= 32'd0;
      s_axil_rresp  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_data_c;
            s_axil_rresp  <= rd_resp_c;
            rd_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            rd_state      <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/accel_ctrl_regs.md
# accel_ctrl_regs

AXI-Lite control/status register block that sits directly upstream of `compute_wrapper` and drives its control plane. It generates `start` and `sw_clear_done` pulses, holds `cfg_k`, tracks busy/done state and counts completed jobs. Software accesses it over a 32-bit AXI-Lite slave port.

## Interface
- `ADDR_W`, default 5: AXI-Lite address width; bits [4:2] select the register.
- `K_MAX`, default 64: largest legal `cfg_k`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_axil_awaddr`/`awvalid`/`awready`  in/in/out  ADDR_W/1/1  write address channel.
- `s_axil_wdata`/`wstrb`/`wvalid`/`wready`  in/in/in/out  32/4/1/1  write data channel; `wstrb` is ignored and full-word writes are assumed.
- `s_axil_bresp`/`bvalid`/`bready`  out/out/in  2/1/1  write response.
- `s_axil_araddr`/`arvalid`/`arready`  in/in/out  ADDR_W/1/1  read address channel.
- `s_axil_rdata`/`rresp`/`rvalid`/`rready`  out/out/out/in  32/2/1/1  read data channel.
- `start`  out  1  one-cycle pulse to the core.
- `sw_clear_done`  out  1  one-cycle pulse that clears the core's sticky `done`.
- `cfg_k`  out  16  K dimension to the core.
- `done`  in  1  sticky done from the core.

## Operation
- Register map:
  - 0x00 CTRL (WO): bit0 START, bit1 CLEAR_DONE. Writing 1 to a bit generates its pulse. Reads return 0.
  - 0x04 STATUS (RO): bit0 DONE (mirrors `done`), bit1 BUSY.
  - 0x08 CFG_K (RW): bits [15:0]; reset value 4.
  - 0x0C JOB_CNT (RO): 32-bit count of `done` rising edges; wraps 0xFFFFFFFF→0.
- START handling:
  - Accepted only when BUSY=0. An accepted START pulses `start` and sets BUSY.
  - START written while BUSY=1 is dropped: no pulse, response OKAY.
- BUSY clears on a `done` rising edge, detected with a registered `done_q`. That same edge increments JOB_CNT.
- CTRL write with both bits set: `sw_clear_done` and `start` pulse in the same cycle, subject to the BUSY rule for START.
- CFG_K write rules:
  - Rejected with SLVERR and value unchanged if BUSY=1, if the value is 0, or if the value is > K_MAX.
  - Otherwise stored with response OKAY.
- Writes to RO registers are ignored with response OKAY.
- Unmapped addresses 0x10–0x1C: reads return 0 with SLVERR; writes return SLVERR.
- Write FSM, W_IDLE → W_RESP:
  - In W_IDLE, when `awvalid && wvalid`: assert `awready` and `wready` for one cycle, perform the register write, go to W_RESP.
  - In W_RESP: hold `bvalid` until `bready`, then return to W_IDLE. AW/W are not accepted in W_RESP.
- Read FSM, R_IDLE → R_DATA:
  - In R_IDLE, when `arvalid`: pulse `arready`, register `rdata`/`rresp`, go to R_DATA.
  - In R_DATA: hold `rvalid` until `rready`.
- Read and write channels operate independently. A same-cycle read of a register being written returns the old value.

## Timing
- Reset values:
  - Low: all `*ready`, `bvalid`, `rvalid`, `start`, `sw_clear_done`.
  - Zero: `bresp`, `rresp`, `rdata`, BUSY, JOB_CNT, `done_q`.
  - `cfg_k` = 4.
- Write latency:
  - `start`/`sw_clear_done` are high in the cycle after the AW/W handshake, for exactly 1 cycle.
  - `bvalid` rises in that same cycle.
  - A CFG_K update is visible on `cfg_k` in the cycle after the handshake.
- Read latency: `rvalid` rises 1 cycle after the AR handshake. Minimum 2 cycles per read and 2 cycles per write.
- Same-cycle `done` rising edge and accepted START: cannot occur, because START requires BUSY=0 and `done` can only rise while BUSY=1. If an external `done` glitch does rise while BUSY=0, JOB_CNT still increments.
- Same-cycle `done` rising edge and START write while BUSY: the START is dropped; BUSY clears in the following cycle.
- Reset asserted mid-transaction: all FSMs return to IDLE and any pending response is lost. The master must re-issue after reset.

## Configuration
- Macro `ACCEL_CTRL_IRQ_EN`.
- Defined:
  - Adds port `irq`  out  1.
  - Adds register 0x10 IER (RW, bit0) and register 0x14 ISR (W1C, bit0).
  - ISR bit0 sets on a `done` rising edge. `irq` = ISR[0] & IER[0], registered, reset 0.
  - A set and a W1C clear in the same cycle: set wins.
- Undefined: no `irq` port; 0x10 and 0x14 behave as unmapped.

## Structure
- Shared package `accel_csr_pkg`:
  - Register offset localparams.
  - AXI resp codes: OKAY=2'b00, SLVERR=2'b10.
  - `cfg_k` reset value 4.
  - Write and read FSM state enums.
- No sub-module: a single flat module.

## Test plan
- Reset release → read 0x08 returns 4 OKAY; read 0x04 returns 0; `start`=0, `cfg_k`=4.
- Write CFG_K=16 → OKAY, `cfg_k`=16. Write 0 → SLVERR, `cfg_k` stays 16. Write 65 → SLVERR.
- Write CTRL=1 → `start` high 1 cycle, STATUS=0x2. Write CTRL=1 again while busy → no pulse, OKAY. Write CFG_K=8 while busy → SLVERR.
- Core raises `done` → STATUS=0x1, JOB_CNT=1. Write CTRL=3 → `sw_clear_done` and `start` pulse in the same cycle. Second `done` → JOB_CNT=2.
- Hold `bready`/`rready` low for 10 cycles → `bvalid`/`rvalid` stay high with stable data; no new AW/W/AR accepted.
- With `ACCEL_CTRL_IRQ_EN`: IER=1, job completes → `irq`=1. Write ISR=1 → `irq`=0 next cycle. Read 0x1C → SLVERR.
